// File: rtl/sm_sub_pkg.sv
// Shared types and defaults for the sign-magnitude subtractor arbiter.
// The optional ops counter is enabled by defining SM_SUB_STATS_EN.
package sm_sub_pkg;

   localparam int W_DEF       = 32;
   localparam int NUM_REQ_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Sign bit on top, magnitude below.
   typedef struct packed {
      logic             sign;
      logic [W_DEF-2:0] mag;
   } sm_word_t;

   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/sm_sub_arbiter_if.sv
// Request/response bundle between requesters, consumer and the shared subtractor.
interface sm_sub_arbiter_if
   import sm_sub_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int W       = W_DEF
);
   localparam int IDW = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0][W-1:0] req_a;
   logic [NUM_REQ-1:0][W-1:0] req_b;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [IDW-1:0]            rsp_id;
   logic [W-1:0]              rsp_diff;
   logic                      rsp_ovf;
   logic [15:0]               ops_count;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_ovf, ops_count
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_ovf, ops_count
   );

endinterface

// File: rtl/sm_sub_core.sv
// Combinational sign-magnitude a-b with magnitude saturation.
// Negative zero on input is read as +0 and never produced on output.
module sm_sub_core #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         ovf
);
   logic [W-2:0] mag_a;
   logic [W-2:0] mag_b;
   logic         sign_a;
   logic         sign_nb;
   logic [W-1:0] sum;
   logic [W-2:0] mag_res;
   logic         sign_res;

   always_comb begin
      mag_a    = a[W-2:0];
      mag_b    = b[W-2:0];
      sign_a   = a[W-1] & (|mag_a);
      // a - b is treated as a + (-b); flipping the sign of a zero b keeps it +0.
      sign_nb  = ~b[W-1] & (|mag_b);
      sum      = {1'b0, mag_a} + {1'b0, mag_b};
      mag_res  = '0;
      sign_res = 1'b0;
      ovf      = 1'b0;
      if (sign_a == sign_nb) begin
         sign_res = sign_a;
         if (sum[W-1]) begin
            mag_res = '1;
            ovf     = 1'b1;
         end else begin
            mag_res = sum[W-2:0];
         end
      end else if (mag_a >= mag_b) begin
         mag_res  = mag_a - mag_b;
         sign_res = sign_a;
      end else begin
         mag_res  = mag_b - mag_a;
         sign_res = sign_nb;
      end
      diff = {sign_res & (|mag_res), mag_res};
   end

endmodule

// File: rtl/sm_sub_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude subtractor: IDLE -> CALC -> RESP.
// Define SM_SUB_STATS_EN to build the saturating completed-operation counter.
module sm_sub_arbiter
   import sm_sub_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int W       = W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   sm_sub_arbiter_if.slave  bus
);
   localparam int IDW = id_width(NUM_REQ);
   localparam int CW  = IDW + 1;

   state_t         state_reg;
   state_t         state_next;
   logic [IDW-1:0] last_grant_reg;
   logic [IDW-1:0] id_reg;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [W-1:0]   diff_reg;
   logic           ovf_reg;

   logic [IDW-1:0] grant_idx;
   logic           any_req;
   logic           accept;
   logic [W-1:0]   core_diff;
   logic           core_ovf;

   // Scan offsets from farthest to nearest so the requester right after last_grant wins.
   always_comb begin
      logic [CW-1:0] cand;
      grant_idx = '0;
      any_req   = 1'b0;
      cand      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, last_grant_reg} + CW'(i + 1);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (bus.req_valid[cand[IDW-1:0]]) begin
            grant_idx = cand[IDW-1:0];
            any_req   = 1'b1;
         end
      end
   end

   assign accept = (state_reg == IDLE) && any_req && !rst;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign bus.req_ready[gi] = accept && (grant_idx == IDW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (any_req) state_next = CALC;
         CALC: state_next = RESP;
         RESP: if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.rsp_valid = (state_reg == RESP);
      bus.rsp_id    = id_reg;
      bus.rsp_diff  = diff_reg;
      bus.rsp_ovf   = ovf_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_reg <= IDW'(NUM_REQ - 1);
         id_reg         <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         diff_reg       <= '0;
         ovf_reg        <= 1'b0;
      end else begin
         if (accept) begin
            last_grant_reg <= grant_idx;
            id_reg         <= grant_idx;
            a_reg          <= bus.req_a[grant_idx];
            b_reg          <= bus.req_b[grant_idx];
         end
         if (state_reg == CALC) begin
            diff_reg <= core_diff;
            ovf_reg  <= core_ovf;
         end
      end
   end

   sm_sub_core #(.W(W)) u_core (
      .a    (a_reg),
      .b    (b_reg),
      .diff (core_diff),
      .ovf  (core_ovf)
   );

`ifdef SM_SUB_STATS_EN
   logic [15:0] ops_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ops_count_reg <= '0;
      end else if ((state_reg == RESP) && bus.rsp_ready && (ops_count_reg != 16'hFFFF)) begin
         ops_count_reg <= ops_count_reg + 16'd1;
      end
   end

   assign bus.ops_count = ops_count_reg;
`else
   assign bus.ops_count = '0;
`endif

endmodule
